mulf_sched: RTL and testbench

- Round-robin scheduler sharing one combinational single-precision float multiplier (`mulf`) among NREQ requesters.
- Accepts one operand pair at a time over per-requester valid/ready handshakes.
- Drives the shared multiplier's operand inputs from registers, waits LAT cycles for the result to settle, then returns it with the requester's ID over a valid/ready response channel.
- Sits between the ALU front-end ports and the single `mulf` instance.

---
 rtl/mulf_sched_if.sv | 37 +++
 rtl/mulf_sched.sv | 157 +++++++++++++++
 tb/tb_mulf_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mulf_sched_if.sv
// rtl/mulf_sched_if.sv - handshake and shared-multiplier bundle for mulf_sched
// Purpose: groups the requester handshakes, the response channel and the
//          shared multiplier operand/product wires of mulf_sched.
// Signals:
//   req_valid/req_ready    NREQ-bit per-requester handshake
//   req_a/req_b            packed operands, requester i at [32i+31:32i]
//   resp_valid/resp_ready  response handshake
//   resp_id/resp_data      owning requester index and product bits
//   mul_a/mul_b            operands to the shared multiplier
//   mul_s                  product from the shared multiplier
// Modports: slave = scheduler side, master = front-end/multiplier side.
interface mulf_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic               resp_valid;
   logic               resp_ready;
   logic [IDW-1:0]     resp_id;
   logic [31:0]        resp_data;
   logic [31:0]        mul_a;
   logic [31:0]        mul_b;
   logic [31:0]        mul_s;

   modport slave (
      input  req_valid, req_a, req_b, resp_ready, mul_s,
      output req_ready, resp_valid, resp_id, resp_data, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, resp_ready, mul_s,
      input  req_ready, resp_valid, resp_id, resp_data, mul_a, mul_b
   );
endinterface

// File: rtl/mulf_sched.sv
// rtl/mulf_sched.sv - round-robin scheduler for one shared float multiplier
// Purpose: arbitrates NREQ requesters onto a single combinational mulf,
//          holds its operands in registers for LAT settle cycles, then
//          returns the product tagged with the requester index.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     mulf_sched_if.slave: requester handshakes, response channel,
//           shared multiplier operands (mul_a/mul_b) and product (mul_s)
//   o_busy  high whenever the scheduler is not idle
module mulf_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   mulf_sched_if.slave bus,
   output logic        o_busy
);
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [IDW-1:0]  r_resp_id;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_mul_a;
   logic [31:0]     r_mul_b;
   logic [31:0]     r_resp_data;

   logic [2*NREQ-1:0] w_rot;
   logic [IDW-1:0]  w_off;
   logic [IDW:0]    w_sum;
   logic [IDW-1:0]  w_grant;
   logic [IDW-1:0]  w_ptr_next;
   logic            w_any;
   logic [31:0]     w_sel_a;
   logic [31:0]     w_sel_b;
   logic            w_win;
   logic            w_accept;
   logic            w_busy;
   logic            w_resp_valid;
   logic [NREQ-1:0] w_req_ready;

   // Rotate the request vector so that bit 0 is the requester at r_ptr;
   // the first set bit then gives the distance from the pointer.
   always_comb begin
      w_rot = {bus.req_valid, bus.req_valid} >> r_ptr;
      w_any = 1'b0;
      w_off = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_rot[k] && !w_any) begin
            w_any = 1'b1;
            w_off = IDW'(k);
         end
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= (IDW+1)'(NREQ)) begin
         w_sum = w_sum - (IDW+1)'(NREQ);
      end
      w_grant = w_sum[IDW-1:0];
      w_ptr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
   end

   // Operand mux for the granted lane.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_grant == IDW'(k)) begin
            w_sel_a = bus.req_a[k*32 +: 32];
            w_sel_b = bus.req_b[k*32 +: 32];
         end
      end
   end

   // FSM: state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM: next state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_WAIT;
         ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
         ST_RESP: begin
            if (bus.resp_ready) begin
               w_next = w_accept ? ST_WAIT : ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM: outputs. A new pair is taken when idle, or in RESP on the same
   // cycle the current result is handed off (back-to-back operation).
   always_comb begin
      w_busy       = (r_state != ST_IDLE);
      w_resp_valid = (r_state == ST_RESP);
      w_win        = (r_state == ST_IDLE) ||
                     ((r_state == ST_RESP) && bus.resp_ready);
      w_accept     = w_win && w_any;
      w_req_ready  = '0;
      if (w_accept) begin
         w_req_ready = NREQ'(1) << w_grant;
      end
   end

   // Datapath: operands only move on accept edges so mul_s can settle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr       <= '0;
         r_id        <= '0;
         r_cnt       <= '0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_resp_id   <= '0;
         r_resp_data <= '0;
      end else if (w_accept) begin
         r_mul_a <= w_sel_a;
         r_mul_b <= w_sel_b;
         r_id    <= w_grant;
         r_ptr   <= w_ptr_next;
         r_cnt   <= CNT_INIT;
      end else if (r_state == ST_WAIT) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else begin
            r_resp_data <= bus.mul_s;
            r_resp_id   <= r_id;
         end
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_id    = r_resp_id;
   assign bus.resp_data  = r_resp_data;
   assign bus.mul_a      = r_mul_a;
   assign bus.mul_b      = r_mul_b;
   assign o_busy         = w_busy;
endmodule

// File: tb/tb_mulf_sched.sv
// tb/tb_mulf_sched.sv - self-checking bench for mulf_sched
module tb_mulf_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int LAT  = 2;

   typedef struct {
      int          id;
      logic [31:0] d;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   mulf_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   // Stand-in multiplier: any bijective function exposes routing errors.
   assign bus.mul_s = bus.mul_a ^ bus.mul_b;

   mulf_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus    (bus),
      .o_busy (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Transaction-level reference model.
   int          m_ptr;
   bit          m_inflight;
   bit          m_have;
   int          m_acc_cyc;
   logic [31:0] m_a;
   logic [31:0] m_b;
   resp_t       m_q[$];
   int          glog[$];
   int          acclog[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr      = 0;
      m_inflight = 0;
      m_have     = 0;
      m_a        = '0;
      m_b        = '0;
      m_q.delete();
   endtask

   // One clock: compare at the falling edge, advance the model, then
   // return just after the next rising edge so inputs can be changed.
   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      int g;
      bit win;
      @(negedge clk);
      if (rst) begin
         model_reset();
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_resp_valid", bus.resp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_mul_a", bus.mul_a, 0);
         chk("rst_mul_b", bus.mul_b, 0);
         chk("rst_resp_id", bus.resp_id, 0);
         chk("rst_resp_data", bus.resp_data, 0);
      end else begin
         if (m_inflight && cyc == m_acc_cyc + LAT + 1) begin
            m_inflight = 0;
            m_have     = 1;
         end
         win = (!m_inflight && !m_have) || (m_have && bus.resp_ready);
         g = win ? model_grant(bus.req_valid, m_ptr) : -1;
         exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
         chk("req_ready", bus.req_ready, exp_rdy);
         chk("resp_valid", bus.resp_valid, m_have);
         chk("busy", busy, m_inflight || m_have);
         chk("mul_a", bus.mul_a, m_a);
         chk("mul_b", bus.mul_b, m_b);
         if (m_have) begin
            if (m_q.size() == 0) begin
               chk("model_queue", 0, 1);
            end else begin
               chk("resp_id", bus.resp_id, m_q[0].id);
               chk("resp_data", bus.resp_data, m_q[0].d);
            end
            if (bus.resp_ready) begin
               if (m_q.size() != 0) void'(m_q.pop_front());
               m_have = 0;
            end
         end
         if (g >= 0) begin
            m_a = bus.req_a[g*32 +: 32];
            m_b = bus.req_b[g*32 +: 32];
            m_q.push_back('{id: g, d: m_a ^ m_b});
            m_inflight = 1;
            m_acc_cyc  = cyc;
            m_ptr      = (g + 1) % NREQ;
            glog.push_back(g);
            acclog.push_back(cyc);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic wait_accept(input string tag);
      int n0;
      n0 = glog.size();
      for (int i = 0; i < 12 && glog.size() == n0; i++) step();
      chk(tag, glog.size(), n0 + 1);
   endtask

   task automatic drain();
      bus.req_valid  = '0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
   endtask

   initial begin
      model_reset();
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b0;

      // Reset, then idle.
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("idle_busy", busy, 0);

      // Single request from requester 2; result appears LAT+1 edges later.
      bus.req_a[2*32 +: 32] = 32'h4000_0000;
      bus.req_b[2*32 +: 32] = 32'h4040_0000;
      bus.req_valid  = 4'b0100;
      bus.resp_ready = 1'b1;
      glog.delete();
      wait_accept("single_accept_tmo");
      chk("single_grant", glog[0], 2);
      bus.req_valid = '0;
      step();
      chk("single_early_valid", bus.resp_valid, 0);
      step();
      chk("single_valid_t3", bus.resp_valid, 1);
      chk("single_id", bus.resp_id, 2);
      chk("single_data", bus.resp_data, 32'h0040_0000);
      drain();

      // Reset while waiting on the multiplier: no response may appear.
      bus.req_a[0 +: 32] = 32'h1234_5678;
      bus.req_b[0 +: 32] = 32'h0f0f_0f0f;
      bus.req_valid = 4'b0001;
      wait_accept("rstwait_accept_tmo");
      bus.req_valid = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("rstwait_no_resp", bus.resp_valid, 0);

      // All four requesting: strict rotation starting from 0, one accept
      // every LAT+1 cycles.
      for (int k = 0; k < NREQ; k++) begin
         bus.req_a[k*32 +: 32] = $urandom();
         bus.req_b[k*32 +: 32] = $urandom();
      end
      glog.delete();
      acclog.delete();
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 16; i++) step();
      chk("rr_count", glog.size() >= 5, 1);
      if (glog.size() >= 5) begin
         chk("rr_g0", glog[0], 0);
         chk("rr_g1", glog[1], 1);
         chk("rr_g2", glog[2], 2);
         chk("rr_g3", glog[3], 3);
         chk("rr_g4", glog[4], 0);
         for (int i = 1; i < 5; i++) chk("rr_spacing", acclog[i] - acclog[i-1], LAT + 1);
      end
      drain();

      // Fairness: park the pointer at 2, then 1 and 3 must alternate.
      bus.req_valid = 4'b0010;
      wait_accept("fair_setup_tmo");
      glog.delete();
      bus.req_valid = 4'b1010;
      for (int i = 0; i < 13; i++) step();
      chk("fair_count", glog.size() >= 4, 1);
      if (glog.size() >= 4) begin
         chk("fair_g0", glog[0], 3);
         chk("fair_g1", glog[1], 1);
         chk("fair_g2", glog[2], 3);
         chk("fair_g3", glog[3], 1);
      end
      drain();

      // Backpressure: result held, no accept, operands frozen.
      bus.req_a[0 +: 32] = 32'h3f80_0000;
      bus.req_b[0 +: 32] = 32'h4000_0000;
      bus.req_valid  = 4'b0001;
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 12 && !m_have; i++) step();
      chk("bp_valid", bus.resp_valid, 1);
      for (int i = 0; i < 5; i++) step();
      chk("bp_hold_valid", bus.resp_valid, 1);
      chk("bp_hold_data", bus.resp_data, 32'h7f80_0000);
      chk("bp_hold_id", bus.resp_id, 0);
      chk("bp_hold_rdy", bus.req_ready, 0);
      chk("bp_hold_mul_a", bus.mul_a, 32'h3f80_0000);
      bus.resp_ready = 1'b1;
      #1;
      chk("bp_release_rdy", bus.req_ready, 4'b0001);
      step();
      chk("bp_release_busy", busy, 1);
      drain();

      // A requester that pulses valid only during WAIT is never granted.
      glog.delete();
      bus.req_valid = 4'b0100;
      wait_accept("pulse_setup_tmo");
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      for (int i = 0; i < 6; i++) step();
      chk("pulse_grants", glog.size(), 1);
      chk("pulse_idle_valid", bus.resp_valid, 0);
      chk("pulse_idle_busy", busy, 0);

      // Randomised traffic with random consumer backpressure.
      for (int i = 0; i < 400; i++) begin
         bus.req_valid = NREQ'($urandom());
         for (int k = 0; k < NREQ; k++) begin
            bus.req_a[k*32 +: 32] = $urandom();
            bus.req_b[k*32 +: 32] = $urandom();
         end
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
      chk("final_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
